// File: rtl/tpu_sequencer_if.sv
// Host/TPU-facing bundle for tpu_sequencer; slave = sequencer side, master = host/bench side.
interface tpu_sequencer_if #(
  parameter int BIT_WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter int DEPTH     = 4
);
  logic                               i_start;
  logic [BIT_WIDTH*DEPTH*DEPTH-1:0]   i_wt_mat;
  logic [BIT_WIDTH*DEPTH*DEPTH-1:0]   i_dat_mat;
  logic [ACC_WIDTH*DEPTH-1:0]         i_pe_acc_in;
  logic                               o_busy;
  logic                               o_done;
  logic                               o_tpu_control;
  logic [BIT_WIDTH*DEPTH-1:0]         o_tpu_wt_arr;
  logic [BIT_WIDTH*DEPTH-1:0]         o_tpu_data_arr;
  logic [ACC_WIDTH*DEPTH-1:0]         o_result;

  modport slave (
    input  i_start, i_wt_mat, i_dat_mat, i_pe_acc_in,
    output o_busy, o_done, o_tpu_control, o_tpu_wt_arr, o_tpu_data_arr, o_result
  );

  modport master (
    output i_start, i_wt_mat, i_dat_mat, i_pe_acc_in,
    input  o_busy, o_done, o_tpu_control, o_tpu_wt_arr, o_tpu_data_arr, o_result
  );
endinterface

// File: rtl/tpu_sequencer.sv
// Latches a weight/data matrix pair on start and steps the systolic TPU through load/settle/feed/drain/capture; done 13+DRAIN_CYCLES edges after accept, start ignored while busy.
// Optional macro TPU_SEQ_RELU_EN clamps negative captured accumulator lanes to zero.
module tpu_sequencer #(
  parameter int BIT_WIDTH    = 16,
  parameter int ACC_WIDTH    = 40,
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  tpu_sequencer_if.slave   bus
);
  localparam int COL_W = BIT_WIDTH * DEPTH;
  localparam int MAT_W = COL_W * DEPTH;
  localparam int RES_W = ACC_WIDTH * DEPTH;

  localparam logic [7:0] LAST_LOAD  = 8'(DEPTH - 1);
  localparam logic [7:0] LAST_FEED  = 8'(2 * DEPTH - 2);
  localparam logic [7:0] LAST_DRAIN = 8'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_SETTLE, S_FEED, S_DRAIN, S_CAPTURE, S_DONE
  } state_t;

  state_t             r_state;
  logic [7:0]         r_cnt;
  logic [MAT_W-1:0]   r_wt;
  logic [MAT_W-1:0]   r_dat;
  logic               r_busy;
  logic               r_done;
  logic               r_ctl;
  logic [COL_W-1:0]   r_wt_arr;
  logic [COL_W-1:0]   r_data_arr;
  logic [RES_W-1:0]   r_result;

  state_t             w_state_nxt;
  logic [7:0]         w_cnt_nxt;
  logic               w_accept;
  logic [MAT_W-1:0]   w_wt_src;
  logic [COL_W-1:0]   w_wt_arr_nxt;
  logic [COL_W-1:0]   w_data_arr_nxt;
  logic [RES_W-1:0]   w_result_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (bus.i_start)          w_state_nxt = S_LOAD_W;
      S_LOAD_W:  if (r_cnt == LAST_LOAD)   w_state_nxt = S_SETTLE;
      S_SETTLE:                            w_state_nxt = S_FEED;
      S_FEED:    if (r_cnt == LAST_FEED)   w_state_nxt = S_DRAIN;
      S_DRAIN:   if (r_cnt == LAST_DRAIN)  w_state_nxt = S_CAPTURE;
      S_CAPTURE:                           w_state_nxt = S_DONE;
      S_DONE:                              w_state_nxt = S_IDLE;
      default:                             w_state_nxt = S_IDLE;
    endcase
    w_accept  = (r_state == S_IDLE) && bus.i_start;
    w_cnt_nxt = ((w_state_nxt != r_state) || (r_state == S_IDLE)) ? 8'd0 : r_cnt + 8'd1;
  end

  // Outputs are computed from the upcoming state/count so the registered
  // values line up with the state they belong to; column 0 comes straight
  // from the input on the accept edge because the latch is not yet loaded.
  always_comb begin
    w_wt_src       = w_accept ? bus.i_wt_mat : r_wt;
    w_wt_arr_nxt   = '0;
    w_data_arr_nxt = '0;
    if (w_state_nxt == S_LOAD_W) begin
      for (int c = 0; c < DEPTH; c++) begin
        if (w_cnt_nxt == 8'(c)) w_wt_arr_nxt = w_wt_src[c*COL_W +: COL_W];
      end
    end
    if (w_state_nxt == S_FEED) begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (w_cnt_nxt == 8'(r + j))
            w_data_arr_nxt[r*BIT_WIDTH +: BIT_WIDTH] = r_dat[(DEPTH*r + j)*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

`ifdef TPU_SEQ_RELU_EN
  always_comb begin
    w_result_nxt = '0;
    for (int l = 0; l < DEPTH; l++) begin
      if (!bus.i_pe_acc_in[l*ACC_WIDTH + ACC_WIDTH - 1])
        w_result_nxt[l*ACC_WIDTH +: ACC_WIDTH] = bus.i_pe_acc_in[l*ACC_WIDTH +: ACC_WIDTH];
    end
  end
`else
  always_comb begin
    w_result_nxt = bus.i_pe_acc_in;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_wt       <= '0;
      r_dat      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ctl      <= 1'b0;
      r_wt_arr   <= '0;
      r_data_arr <= '0;
      r_result   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      if (w_accept) begin
        r_wt  <= bus.i_wt_mat;
        r_dat <= bus.i_dat_mat;
      end
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      r_ctl      <= (w_state_nxt == S_LOAD_W);
      r_wt_arr   <= w_wt_arr_nxt;
      r_data_arr <= w_data_arr_nxt;
      if (r_state == S_CAPTURE) r_result <= w_result_nxt;
    end
  end

  assign bus.o_busy         = r_busy;
  assign bus.o_done         = r_done;
  assign bus.o_tpu_control  = r_ctl;
  assign bus.o_tpu_wt_arr   = r_wt_arr;
  assign bus.o_tpu_data_arr = r_data_arr;
  assign bus.o_result       = r_result;
endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed bench for tpu_sequencer: weight load, skew feed, latency, back-to-back start, mid-run reset and ReLU capture.
module tb_tpu_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tpu_sequencer_if bus ();
  tpu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_asrt = 0;
  int n_fail = 0;

  localparam logic [255:0] WT_ID = {64'h0000_0000_0000_0001, 64'h0000_0000_0001_0000,
                                    64'h0000_0001_0000_0000, 64'h0001_0000_0000_0000};
  localparam logic [255:0] WT_B  = {64'h4444_4040_0404_0044, 64'h3333_3030_0303_0033,
                                    64'h2222_2020_0202_0022, 64'h1111_1010_0101_0011};
  localparam logic [159:0] STUB_A = {40'd3, 40'd0, 40'd0, 40'd0};
  localparam logic [159:0] STUB_B = {40'd0, 40'd0, 40'd5, 40'hFF_FFFF_FFFE};
`ifdef TPU_SEQ_RELU_EN
  localparam logic [159:0] RES_B  = {40'd0, 40'd0, 40'd5, 40'd0};
`else
  localparam logic [159:0] RES_B  = {40'd0, 40'd0, 40'd5, 40'hFF_FFFF_FFFE};
`endif

  logic [63:0] feed_exp [7] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0004_0001,
                                64'h0000_0008_0005_0002, 64'h000c_0009_0006_0003,
                                64'h000d_000a_0007_0000, 64'h000e_000b_0000_0000,
                                64'h000f_0000_0000_0000};

  task automatic chk(input string tag, input int n, input logic [159:0] obs, input logic [159:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s n=%0d: got %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  // n = number of rising edges since the accept edge
  task automatic chk_cycle(input int n, input logic [255:0] wt, input logic [159:0] res_new,
                           input logic [159:0] res_old);
    logic [63:0]  we;
    logic [63:0]  de;
    we = 64'h0;
    de = 64'h0;
    if (n <= 3) we = wt[64*n +: 64];
    if (n >= 5 && n <= 11) de = feed_exp[n-5];
    chk("busy",    n, 160'(bus.o_busy),         160'(n <= 21));
    chk("done",    n, 160'(bus.o_done),         160'(n == 21));
    chk("control", n, 160'(bus.o_tpu_control),  160'(n <= 3));
    chk("wt_arr",  n, 160'(bus.o_tpu_wt_arr),   160'(we));
    chk("data_arr",n, 160'(bus.o_tpu_data_arr), 160'(de));
    chk("result",  n, bus.o_result,             (n >= 21) ? res_new : res_old);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},    -1, 160'(bus.o_busy),         160'd0);
    chk({tag, "_done"},    -1, 160'(bus.o_done),         160'd0);
    chk({tag, "_control"}, -1, 160'(bus.o_tpu_control),  160'd0);
    chk({tag, "_wt_arr"},  -1, 160'(bus.o_tpu_wt_arr),   160'd0);
    chk({tag, "_data_arr"},-1, 160'(bus.o_tpu_data_arr), 160'd0);
    chk({tag, "_result"},  -1, bus.o_result,             160'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start     = 1'b0;
    bus.i_wt_mat    = '0;
    bus.i_dat_mat   = '0;
    bus.i_pe_acc_in = '0;
    for (int i = 0; i < 16; i++) bus.i_dat_mat[16*i +: 16] = 16'(i);

    #12;
    chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("idle_busy", -1, 160'(bus.o_busy), 160'd0);

    // Run A: identity weights, start held high through DONE and the following IDLE cycle
    bus.i_wt_mat    = WT_ID;
    bus.i_pe_acc_in = STUB_A;
    bus.i_start     = 1'b1;
    @(posedge clk); @(negedge clk);
    for (int n = 0; n <= 22; n++) begin
      chk_cycle(n, WT_ID, STUB_A, 160'd0);
      if (n == 0) bus.i_wt_mat = WT_B;
      if (n < 22) begin @(posedge clk); @(negedge clk); end
    end

    // Run B: accepted on the edge right after DONE; negative lane exercises ReLU
    bus.i_pe_acc_in = STUB_B;
    @(posedge clk); @(negedge clk);
    for (int n = 0; n <= 22; n++) begin
      chk_cycle(n, WT_B, RES_B, STUB_A);
      if (n == 0)  bus.i_start = 1'b0;
      if (n == 10) bus.i_start = 1'b1;
      if (n == 11) bus.i_start = 1'b0;
      if (n < 22) begin @(posedge clk); @(negedge clk); end
    end
    @(posedge clk); @(negedge clk);
    chk("hold_busy",   -1, 160'(bus.o_busy), 160'd0);
    chk("hold_result", -1, bus.o_result,     RES_B);

    // Run C: reset asserted at FEED k=3
    bus.i_wt_mat    = WT_ID;
    bus.i_pe_acc_in = STUB_A;
    bus.i_start     = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.i_start = 1'b0;
    for (int n = 0; n <= 8; n++) begin
      chk_cycle(n, WT_ID, STUB_A, RES_B);
      if (n < 8) begin @(posedge clk); @(negedge clk); end
    end
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("postrst_busy", -1, 160'(bus.o_busy), 160'd0);

    // Run D: normal single-pulse run after reset
    bus.i_start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.i_start = 1'b0;
    for (int n = 0; n <= 22; n++) begin
      chk_cycle(n, WT_ID, STUB_A, 160'd0);
      if (n < 22) begin @(posedge clk); @(negedge clk); end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
